// File: rtl/ocm_dp_ram_ctrl_if.sv
// ----------------------------------------------------------------------------
// ocm_dp_ram_ctrl_if
// Avalon-MM slave bundle for one port of the dual-port on-chip RAM.
//   address        word address
//   read / write   request strobes, held by the master while waitrequest=1
//   writedata      write data
//   byteenable     byte lane enables for writes
//   waitrequest    1: request not accepted this cycle
//   readdata       read data, valid while readdatavalid=1
//   readdatavalid  one-cycle strobe per accepted read
// ----------------------------------------------------------------------------
interface ocm_dp_ram_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/ocm_dp_ram_ctrl.sv
// ----------------------------------------------------------------------------
// ocm_dp_ram_ctrl
// Single-clock dual-port on-chip RAM behind two Avalon-MM slaves. Pipelined
// reads with readdatavalid (optional output register), same-address write/write
// arbitration in favour of s1, write-to-read forwarding with byte-lane merge,
// and a hardware clear sequence after reset or on clear_req.
// Ports:
//   clk         single clock for both ports
//   reset_n     asynchronous reset, active low
//   s1, s2      Avalon-MM slave ports (ocm_dp_ram_ctrl_if.slave)
//   clear_req   1-clk pulse: zero the whole memory
//   clear_busy  1 while the clear sequence runs
// ----------------------------------------------------------------------------
module ocm_dp_ram_ctrl #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 14,
  parameter int OUT_REG       = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  ocm_dp_ram_ctrl_if.slave s1,
  ocm_dp_ram_ctrl_if.slave s2,
  input  logic             clear_req,
  output logic             clear_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;
  localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? CLEAR : RUN;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              clear_busy_q;
  logic              wait_q;

  logic              ww_col;
  logic              wr1, wr2, rd1, rd2;
  logic              clear_we;
  logic [DATA_W-1:0] rd1_word, rd2_word;

  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  // s2 loses a same-address write/write collision and retries next cycle.
  assign ww_col = s1.write && s2.write && (s1.address == s2.address);

  assign s1.waitrequest = wait_q;
  assign s2.waitrequest = wait_q | ww_col;

  // Read+write on one port is a write only.
  assign wr1 = !wait_q && s1.write;
  assign wr2 = !wait_q && !ww_col && s2.write;
  assign rd1 = !wait_q && s1.read && !s1.write;
  assign rd2 = !wait_q && s2.read && !s2.write;

  // The first edge after reset release only arms clear_busy_q, so a clear
  // writes words 0..DEPTH-1 while clear_busy is visibly high.
  assign clear_we   = (state_q == CLEAR) && clear_busy_q;
  assign clear_busy = clear_busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RST_STATE;
      clr_cnt_q    <= '0;
      clear_busy_q <= 1'b0;
      wait_q       <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          clear_busy_q <= 1'b1;
          wait_q       <= 1'b1;
          if (clear_busy_q) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
              state_q      <= RUN;
              clear_busy_q <= 1'b0;
              wait_q       <= 1'b0;
            end
          end
        end
        default: begin
          clear_busy_q <= 1'b0;
          wait_q       <= 1'b0;
          if (clear_req) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= '0;
            clear_busy_q <= 1'b1;
            wait_q       <= 1'b1;
          end
        end
      endcase
    end
  end

  // Memory array: no reset, contents owned by the clear sequence.
  always_ff @(posedge clk) begin
    if (clear_we) mem[clr_cnt_q] <= '0;
    for (int b = 0; b < BE_W; b++) begin
      if (wr1 && s1.byteenable[b]) mem[s1.address][b*8 +: 8] <= s1.writedata[b*8 +: 8];
      if (wr2 && s2.byteenable[b]) mem[s2.address][b*8 +: 8] <= s2.writedata[b*8 +: 8];
    end
  end

  // A read sees the other port's same-cycle write, merged per byte lane.
  always_comb begin
    rd1_word = mem[s1.address];
    if (wr2 && (s2.address == s1.address))
      rd1_word = lane_merge(rd1_word, s2.writedata, s2.byteenable);
    rd2_word = mem[s2.address];
    if (wr1 && (s1.address == s2.address))
      rd2_word = lane_merge(rd2_word, s1.writedata, s1.byteenable);
  end

  // ---- stage p0: array read registered at the accept edge ----
  logic              vld1_p0, vld2_p0;
  logic [DATA_W-1:0] data1_p0, data2_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld1_p0  <= 1'b0;
      vld2_p0  <= 1'b0;
      data1_p0 <= '0;
      data2_p0 <= '0;
    end else begin
      vld1_p0 <= rd1;
      vld2_p0 <= rd2;
      if (rd1) data1_p0 <= rd1_word;
      if (rd2) data2_p0 <= rd2_word;
    end
  end

  // ---- stage p1: optional output register ----
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              vld1_p1, vld2_p1;
      logic [DATA_W-1:0] data1_p1, data2_p1;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld1_p1  <= 1'b0;
          vld2_p1  <= 1'b0;
          data1_p1 <= '0;
          data2_p1 <= '0;
        end else begin
          vld1_p1 <= vld1_p0;
          vld2_p1 <= vld2_p0;
          if (vld1_p0) data1_p1 <= data1_p0;
          if (vld2_p0) data2_p1 <= data2_p0;
        end
      end

      assign s1.readdatavalid = vld1_p1;
      assign s1.readdata      = data1_p1;
      assign s2.readdatavalid = vld2_p1;
      assign s2.readdata      = data2_p1;
    end else begin : g_noreg
      assign s1.readdatavalid = vld1_p0;
      assign s1.readdata      = data1_p0;
      assign s2.readdatavalid = vld2_p0;
      assign s2.readdata      = data2_p0;
    end
  endgenerate

endmodule

// File: tb/tb_ocm_dp_ram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ocm_dp_ram_ctrl
// Directed bench for ocm_dp_ram_ctrl (DATA_W=32, ADDR_W=4): reset state,
// power-up clear, byte-enable writes, collisions, forwarding, back-to-back
// reads, clear_req with reads in flight and reset during a clear.
// ----------------------------------------------------------------------------
module tb_ocm_dp_ram_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int OUT_REG = 0;
  localparam int LAT = (OUT_REG != 0) ? 2 : 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear_req = 1'b0;
  logic clear_busy;

  int checks = 0;
  int errors = 0;

  ocm_dp_ram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) s1_if ();
  ocm_dp_ram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) s2_if ();

  ocm_dp_ram_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_REG(OUT_REG), .INIT_ON_RESET(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s1(s1_if), .s2(s2_if),
    .clear_req(clear_req), .clear_busy(clear_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic rd, input logic wr, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    if (p == 1) begin
      s1_if.read = rd; s1_if.write = wr; s1_if.address = a;
      s1_if.writedata = d; s1_if.byteenable = be;
    end else begin
      s2_if.read = rd; s2_if.write = wr; s2_if.address = a;
      s2_if.writedata = d; s2_if.byteenable = be;
    end
  endtask

  task automatic write1(input int p, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    set_req(p, 1'b0, 1'b1, a, d, be);
    cyc();
    set_req(p, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
  endtask

  // Single read: checks latency from the accept edge and the returned word.
  task automatic read_chk(input string tag, input int p, input logic [3:0] a, input logic [31:0] exp);
    int lat;
    logic [31:0] d;
    lat = 0;
    d = 32'hx;
    set_req(p, 1'b1, 1'b0, a, 32'h0, 4'h0);
    cyc();
    set_req(p, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if ((p == 1) ? s1_if.readdatavalid : s2_if.readdatavalid) begin
        lat = i + 1;
        d = (p == 1) ? s1_if.readdata : s2_if.readdata;
        break;
      end
    end
    cyc();
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check(tag, d, exp);
  endtask

  // Observes 40 cycles: clear_busy length, waitrequest while busy, read returns.
  task automatic run_clear(output int busy_n, output logic wbad, output int v1, output int v2,
                           output logic [31:0] d1, output logic [31:0] d2);
    busy_n = 0; wbad = 1'b0; v1 = 0; v2 = 0; d1 = 32'hx; d2 = 32'hx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (clear_busy) begin
        busy_n++;
        if (!(s1_if.waitrequest && s2_if.waitrequest)) wbad = 1'b1;
      end
      if (s1_if.readdatavalid) begin v1++; d1 = s1_if.readdata; end
      if (s2_if.readdatavalid) begin v2++; d2 = s2_if.readdata; end
    end
    cyc();
  endtask

  initial begin
    int busy_n, v1, v2, n, first, last;
    logic wbad, stall;
    logic [31:0] d1, d2;
    logic [31:0] got [8];

    set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    set_req(2, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s1_wait", 32'(s1_if.waitrequest), 32'd1);
    check("rst_s2_wait", 32'(s2_if.waitrequest), 32'd1);
    check("rst_s1_vld", 32'(s1_if.readdatavalid), 32'd0);
    check("rst_s2_vld", 32'(s2_if.readdatavalid), 32'd0);
    check("rst_s1_data", s1_if.readdata, 32'h0);
    check("rst_s2_data", s2_if.readdata, 32'h0);
    check("rst_busy", 32'(clear_busy), 32'd0);

    // Power-up clear
    cyc();
    reset_n = 1'b1;
    run_clear(busy_n, wbad, v1, v2, d1, d2);
    check("init_busy_len", 32'(busy_n), 32'd16);
    check("init_wait_busy", 32'(wbad), 32'd0);
    check("init_s1_wait_after", 32'(s1_if.waitrequest), 32'd0);
    check("init_s2_wait_after", 32'(s2_if.waitrequest), 32'd0);
    for (int a = 0; a < 16; a++) read_chk($sformatf("init_rd%0d", a), (a % 2) + 1, 4'(a), 32'h0);

    // Byte-enable write then read from the other port
    write1(1, 4'd3, 32'h11223344, 4'hF);
    write1(1, 4'd3, 32'hDEADBEEF, 4'b0101);
    read_chk("be_merge", 2, 4'd3, 32'h11AD33EF);

    // Read + read on the same address
    set_req(1, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    set_req(2, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    @(negedge clk);
    check("rr_s1_wait", 32'(s1_if.waitrequest), 32'd0);
    check("rr_s2_wait", 32'(s2_if.waitrequest), 32'd0);
    cyc();
    set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    set_req(2, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    repeat (LAT - 1) cyc();
    @(negedge clk);
    check("rr_s1_vld", 32'(s1_if.readdatavalid), 32'd1);
    check("rr_s2_vld", 32'(s2_if.readdatavalid), 32'd1);
    check("rr_s1_data", s1_if.readdata, 32'h11AD33EF);
    check("rr_s2_data", s2_if.readdata, 32'h11AD33EF);
    cyc();

    // Write/write collision on address 7
    set_req(1, 1'b0, 1'b1, 4'd7, 32'hAAAA0000, 4'hF);
    set_req(2, 1'b0, 1'b1, 4'd7, 32'h5555FFFF, 4'hF);
    @(negedge clk);
    check("ww_s1_wait", 32'(s1_if.waitrequest), 32'd0);
    check("ww_s2_wait", 32'(s2_if.waitrequest), 32'd1);
    cyc();
    set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("ww_s2_retry_wait", 32'(s2_if.waitrequest), 32'd0);
    cyc();
    set_req(2, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    read_chk("ww_final", 1, 4'd7, 32'h5555FFFF);

    // Write on s1 + read on s2, same address, same cycle
    write1(2, 4'd9, 32'hFFFFFFFF, 4'hF);
    set_req(1, 1'b0, 1'b1, 4'd9, 32'h12345678, 4'b1100);
    set_req(2, 1'b1, 1'b0, 4'd9, 32'h0, 4'h0);
    cyc();
    set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    set_req(2, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    repeat (LAT - 1) cyc();
    @(negedge clk);
    check("fwd_vld", 32'(s2_if.readdatavalid), 32'd1);
    check("fwd_data", s2_if.readdata, 32'h1234FFFF);
    cyc();
    read_chk("fwd_stored", 1, 4'd9, 32'h1234FFFF);

    // Read and write together on one port: write only, no readdatavalid
    set_req(1, 1'b1, 1'b1, 4'd10, 32'hCAFEF00D, 4'hF);
    cyc();
    set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    v1 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (s1_if.readdatavalid) v1++;
    end
    cyc();
    check("rw_no_vld", 32'(v1), 32'd0);
    read_chk("rw_written", 2, 4'd10, 32'hCAFEF00D);

    // Back-to-back reads of addr 0..7
    for (int a = 0; a < 8; a++) write1(1, 4'(a), 32'(a), 4'hF);
    n = 0; first = -1; last = -1; stall = 1'b0;
    for (int c = 0; c < 8 + LAT + 2; c++) begin
      if (c < 8) set_req(1, 1'b1, 1'b0, 4'(c), 32'h0, 4'h0);
      else set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      @(negedge clk);
      if (c < 8 && s1_if.waitrequest) stall = 1'b1;
      if (s1_if.readdatavalid) begin
        if (n < 8) got[n] = s1_if.readdata;
        n++;
        if (first < 0) first = c;
        last = c;
      end
      cyc();
    end
    check("b2b_count", 32'(n), 32'd8);
    check("b2b_consecutive", 32'(last - first), 32'd7);
    check("b2b_first_lat", 32'(first), 32'(LAT));
    check("b2b_stall", 32'(stall), 32'd0);
    for (int k = 0; k < 8; k++) check($sformatf("b2b_data%0d", k), got[k], 32'(k));

    // clear_req with reads in flight
    set_req(1, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    set_req(2, 1'b1, 1'b0, 4'd6, 32'h0, 4'h0);
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    set_req(2, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    run_clear(busy_n, wbad, v1, v2, d1, d2);
    check("clr_busy_len", 32'(busy_n), 32'd16);
    check("clr_wait_busy", 32'(wbad), 32'd0);
    check("clr_s1_vld_n", 32'(v1), 32'd1);
    check("clr_s2_vld_n", 32'(v2), 32'd1);
    check("clr_s1_old", d1, 32'd5);
    check("clr_s2_old", d2, 32'd6);
    for (int a = 0; a < 16; a++) read_chk($sformatf("clr_rd%0d", a), (a % 2) + 1, 4'(a), 32'h0);

    // Reset during a clear at clr_cnt=5 restarts it from word 0
    write1(1, 4'd15, 32'h00000099, 4'hF);
    write1(2, 4'd0, 32'h00000077, 4'hF);
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    repeat (5) cyc();
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(clear_busy), 32'd0);
    check("midrst_s1_wait", 32'(s1_if.waitrequest), 32'd1);
    check("midrst_s2_wait", 32'(s2_if.waitrequest), 32'd1);
    cyc();
    reset_n = 1'b1;
    run_clear(busy_n, wbad, v1, v2, d1, d2);
    check("restart_busy_len", 32'(busy_n), 32'd16);
    check("restart_wait_busy", 32'(wbad), 32'd0);
    read_chk("restart_rd15", 1, 4'd15, 32'h0);
    read_chk("restart_rd0", 2, 4'd0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
